debug_reg_dumper: RTL and testbench

- Initiator side of the processor's register-file debug read port: drives the debug address and samples the returned debug data.
- On a trigger (typically Ebreak or Ecall from the core, or a host request), walks x0..x31 and captures each value.
- Streams the snapshot as a framed byte sequence over a valid/ready byte interface that feeds a UART TX or trace FIFO.
- Sits in top, beside the core, between the register-file debug port and the byte sink.

---
 rtl/debug_pkg.sv | 15 +
 rtl/debug_reg_dumper.sv | 119 +++++++++++
 tb/tb_debug_reg_dumper.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the register-file debug dumper.
package debug_pkg;

    typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, CSUM} dump_state_t;

    localparam logic [7:0]  DBG_SYNC_BYTE = 8'hA5;
    localparam int unsigned DBG_NREGS     = 32;

    // Total bytes on the wire: sync header, register payload, checksum.
    function automatic int unsigned frame_len(input int unsigned nregs,
                                              input int unsigned xlen);
        return 2 + nregs * xlen / 8;
    endfunction

endpackage

// File: rtl/debug_reg_dumper.sv
// Walks x0..x(NREGS-1) over the register-file debug read port and streams a framed,
// checksummed snapshot (sync, MSB-first words, 8-bit sum) over a valid/ready byte link.
module debug_reg_dumper
    import debug_pkg::*;
#(
    parameter int unsigned NREGS     = DBG_NREGS,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned XLEN      = 32,
    parameter logic [7:0]  SYNC_BYTE = DBG_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_trigger,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_debug_addr,
    input  logic [XLEN-1:0]   i_debug_data,
    output logic [7:0]        o_byte,
    output logic              o_byte_valid,
    input  logic              i_byte_ready,
    output logic              o_done
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NREGS - 1);

    dump_state_t       state;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  byte_cnt;
    logic [XLEN-1:0]   shadow;
    logic [7:0]        checksum;
    logic [7:0]        csum_next;
    logic [7:0]        next_byte;
    logic [XLEN-1:0]   shifted;
    logic              xfer;

    assign xfer      = o_byte_valid && i_byte_ready;
    assign csum_next = checksum + o_byte;

    // Byte following the one currently on o_byte, taken MSB-first from the shadow word.
    always_comb begin
        shifted   = shadow << (8 * (int'(byte_cnt) + 1));
        next_byte = shifted[XLEN-1 -: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            o_busy       <= 1'b0;
            o_debug_addr <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_done       <= 1'b0;
            index        <= '0;
            byte_cnt     <= '0;
            shadow       <= '0;
            checksum     <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_trigger) begin
                        state        <= HDR;
                        o_byte       <= SYNC_BYTE;
                        o_byte_valid <= 1'b1;
                        o_busy       <= 1'b1;
                        index        <= '0;
                        checksum     <= '0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state        <= FETCH;
                        o_debug_addr <= index;
                        o_byte_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    // Address has been stable for this whole cycle; the read is settled.
                    state        <= SEND;
                    shadow       <= i_debug_data;
                    o_byte       <= i_debug_data[XLEN-1 -: 8];
                    o_byte_valid <= 1'b1;
                    byte_cnt     <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        checksum <= csum_next;
                        if (byte_cnt == LAST_BYTE) begin
                            if (index == LAST_REG) begin
                                state  <= CSUM;
                                o_byte <= csum_next;
                            end else begin
                                state        <= FETCH;
                                index        <= index + 1'b1;
                                o_debug_addr <= index + 1'b1;
                                o_byte_valid <= 1'b0;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            o_byte   <= next_byte;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        state        <= IDLE;
                        o_byte_valid <= 1'b0;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Randomized bench for debug_reg_dumper: a register array model answers the debug port
// and every streamed frame is compared against a frame built directly from the array.
module tb_debug_reg_dumper;
    import debug_pkg::*;

    localparam int unsigned NREGS = 32;
    localparam int unsigned XLEN  = 32;

    logic        clk;
    logic        rst;
    logic        i_trigger;
    logic        o_busy;
    logic [4:0]  o_debug_addr;
    logic [31:0] i_debug_data;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        i_byte_ready;
    logic        o_done;

    logic [31:0] regs [NREGS];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    int checks;
    int failures;

    debug_reg_dumper dut (
        .clk          (clk),
        .rst          (rst),
        .i_trigger    (i_trigger),
        .o_busy       (o_busy),
        .o_debug_addr (o_debug_addr),
        .i_debug_data (i_debug_data),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_done       (o_done)
    );

    assign i_debug_data = regs[o_debug_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected frame: sync, each register MSB first, then the 8-bit sum of the data bytes.
    task automatic build_expected();
        int sum;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < NREGS; r++) begin
            for (int b = XLEN / 8 - 1; b >= 0; b--) begin
                exp_q.push_back(8'((regs[r] >> (8 * b)) & 32'hFF));
                sum += int'((regs[r] >> (8 * b)) & 32'hFF);
            end
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_valid"}, 32'(o_byte_valid), 0);
        chk({tag, "_addr"}, 32'(o_debug_addr), 0);
        chk({tag, "_byte"}, 32'(o_byte), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
    endtask

    // mode 0: ready held high, 1: ready toggles, 2: random stalls.
    // trig_byte >= 0 pulses a stray trigger once that many bytes are out;
    // trig_csum pulses a trigger on the checksum transfer edge;
    // rst_byte >= 0 resets mid-cycle once that many bytes are out.
    task automatic run_frame(input int mode, input int trig_byte, input bit trig_csum,
                             input int rst_byte);
        int         edges;
        int         ndone;
        int         done_edge;
        bit         stalled;
        bit         aborted;
        bit         finished;
        logic [7:0] stall_byte;

        build_expected();
        got_q.delete();
        ndone     = 0;
        done_edge = -1;
        stalled   = 1'b0;
        aborted   = 1'b0;
        finished  = 1'b0;
        stall_byte = '0;

        @(negedge clk);
        i_trigger    = 1'b1;
        i_byte_ready = 1'b1;
        @(posedge clk);
        #1 i_trigger = 1'b0;
        @(negedge clk);
        chk("busy_after_trigger", 32'(o_busy), 1);
        chk("sync_valid", 32'(o_byte_valid), 1);
        edges = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stalled) begin
                chk("stall_hold_byte", 32'(o_byte), 32'(stall_byte));
                chk("stall_hold_valid", 32'(o_byte_valid), 1);
            end
            if (o_done) begin
                ndone++;
                if (done_edge < 0) done_edge = edges;
            end
            if (done_edge >= 0 && edges >= done_edge + 6) begin
                finished = 1'b1;
                break;
            end
            if (rst_byte >= 0 && got_q.size() == rst_byte) begin
                #2 rst = 1'b1;
                #1 check_idle_outputs("async_reset");
                #1 rst = 1'b0;
                i_trigger = 1'b0;
                aborted   = 1'b1;
                break;
            end

            case (mode)
                0:       i_byte_ready = 1'b1;
                1:       i_byte_ready = (cyc % 2 == 0);
                default: i_byte_ready = ($urandom_range(0, 3) != 0);
            endcase
            i_trigger = (trig_byte >= 0 && got_q.size() == trig_byte) ||
                        (trig_csum && o_byte_valid && i_byte_ready &&
                         got_q.size() == exp_q.size() - 1);

            if (o_byte_valid && i_byte_ready) begin
                if (got_q.size() >= 1 && got_q.size() <= NREGS * XLEN / 8)
                    chk("addr_align", 32'(o_debug_addr), 32'((got_q.size() - 1) / (XLEN / 8)));
                got_q.push_back(o_byte);
                stalled = 1'b0;
            end else if (o_byte_valid) begin
                stalled    = 1'b1;
                stall_byte = o_byte;
            end else begin
                stalled = 1'b0;
            end

            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        i_trigger = 1'b0;

        if (!aborted) begin
            chk("frame_completed", 32'(finished), 1);
            chk("done_count", 32'(ndone), 1);
            chk("byte_count", 32'(got_q.size()), frame_len(NREGS, XLEN));
            if (got_q.size() == exp_q.size()) begin
                for (int i = 0; i < exp_q.size(); i++)
                    chk($sformatf("stream_byte_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
            end
            if (mode == 0) chk("done_latency", 32'(done_edge), 162);
            chk("idle_busy_after_done", 32'(o_busy), 0);
            chk("idle_valid_after_done", 32'(o_byte_valid), 0);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        i_trigger    = 1'b0;
        i_byte_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = '0;

        #1 check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Known frame: only x1 non-zero.
        regs[1] = 32'hABCDE02E;
        run_frame(0, -1, 1'b0, -1);
        if (got_q.size() == 130) chk("known_checksum", 32'(got_q[129]), 32'h86);

        // Backpressure with random register contents.
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom();
        run_frame(1, -1, 1'b0, -1);
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom();
        run_frame(2, -1, 1'b0, -1);

        // Stray triggers mid-frame and on the completing edge.
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom();
        run_frame(0, 40, 1'b1, -1);

        // Reset mid-frame, then a fresh frame.
        run_frame(2, -1, 1'b0, 50);
        repeat (2) @(negedge clk);
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom();
        run_frame(0, -1, 1'b0, -1);

        // Per-word pattern xk = 0x01010101 * k.
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h01010101 * 32'(i);
        run_frame(2, -1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
